// File: rtl/mem_txn_tracker.sv
// In-order memory command tracker between the instruction scheduler and the TX/RX serial engines.
// Queues commands, issues them one at a time, and pairs RX replies with the oldest entry that wants one.
//
// state      | meaning
// ISSUE_IDLE | no command in TX; offer the entry at iss_ptr when one is queued
// INFLIGHT   | TX owns the command at infl_ptr; waiting for tx_done
module mem_txn_tracker #(
    parameter int NSHIFT         = 2,
    parameter int PAYLOAD_CYCLES = 8,
    parameter int DEPTH          = 4,
    parameter int CMD_BITS       = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [CMD_BITS-1:0]        req_cmd,
    input  logic                       req_reply_wanted,
    input  logic                       flush,
    output logic                       tx_command_valid,
    output logic [CMD_BITS-1:0]        tx_command,
    input  logic                       tx_command_started,
    input  logic                       tx_done,
    input  logic                       rx_started,
    input  logic                       rx_data_valid,
    input  logic                       rx_done,
    output logic                       reply_active,
    output logic [$clog2(DEPTH)-1:0]   reply_tag,
    output logic                       reply_hi_half,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       idle,
    output logic                       err_unexpected
);

    localparam int AW       = $clog2(DEPTH);
    localparam int PW       = AW + 1;
    localparam int CW       = $clog2(PAYLOAD_CYCLES) + 1;
    localparam int HALF_BIT = $clog2(PAYLOAD_CYCLES) - 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // A reply is always 16 payload bits, so the beat geometry must multiply out to that.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NSHIFT * PAYLOAD_CYCLES != 16) begin : g_bad_params
        $error("mem_txn_tracker: unsupported parameter set");
    end

    typedef enum logic {ISSUE_IDLE, INFLIGHT} issue_state_t;

    issue_state_t          state;
    logic [CMD_BITS-1:0]   cmd_mem [DEPTH];
    logic [DEPTH-1:0]      rw_q;
    logic [DEPTH-1:0]      sent_q;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         iss_ptr;
    logic [PW-1:0]         ret_ptr;
    logic [PW-1:0]         infl_ptr;
    logic [CW-1:0]         beat_cnt;

    logic [AW-1:0]         head_idx;
    logic [PW-1:0]         occupancy;
    logic                  nonempty;
    logic                  full;
    logic                  head_inflight;
    logic                  reply_ok;
    logic                  retire;
    logic                  issue;
    logic                  accept;

    always_comb begin
        head_idx      = ret_ptr[AW-1:0];
        occupancy     = wr_ptr - ret_ptr;
        nonempty      = (wr_ptr != ret_ptr);
        full          = (occupancy == PW'(DEPTH));
        head_inflight = (state == INFLIGHT) && (infl_ptr == ret_ptr);
        // RX may beat tx_done, so a head still in TX qualifies as the reply owner.
        reply_ok      = nonempty && rw_q[head_idx] && (sent_q[head_idx] || head_inflight);
        retire        = nonempty &&
                        ((!rw_q[head_idx] && sent_q[head_idx]) ||
                         (rw_q[head_idx] && rx_done && reply_active));
        issue         = (state == ISSUE_IDLE) && (iss_ptr != wr_ptr) && tx_command_started;
        accept        = req_valid && req_ready;
    end

    assign req_ready        = !full && !flush;
    assign tx_command_valid = (state == ISSUE_IDLE) && (iss_ptr != wr_ptr);
    assign tx_command       = cmd_mem[iss_ptr[AW-1:0]];
    assign reply_tag        = ret_ptr[AW-1:0];
    assign reply_hi_half    = beat_cnt[HALF_BIT];
    assign outstanding      = occupancy;
    assign idle             = (occupancy == '0) && (state == ISSUE_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ISSUE_IDLE;
            for (int i = 0; i < DEPTH; i++) cmd_mem[i] <= '0;
            rw_q           <= '0;
            sent_q         <= '0;
            wr_ptr         <= '0;
            iss_ptr        <= '0;
            ret_ptr        <= '0;
            infl_ptr       <= '0;
            beat_cnt       <= '0;
            reply_active   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            if (retire) begin
                sent_q[head_idx] <= 1'b0;
                ret_ptr          <= ret_ptr + PTR_ONE;
            end

            case (state)
                ISSUE_IDLE: begin
                    if (issue) begin
                        state    <= INFLIGHT;
                        infl_ptr <= iss_ptr;
                        iss_ptr  <= iss_ptr + PTR_ONE;
                    end
                end
                INFLIGHT: begin
                    if (tx_done) begin
                        sent_q[infl_ptr[AW-1:0]] <= 1'b1;
                        state                    <= ISSUE_IDLE;
                    end
                end
                default: state <= ISSUE_IDLE;
            endcase

            // A command started in the flush cycle survives; everything behind it is dropped.
            if (flush) begin
                wr_ptr <= issue ? iss_ptr + PTR_ONE : iss_ptr;
            end else if (accept) begin
                cmd_mem[wr_ptr[AW-1:0]] <= req_cmd;
                rw_q[wr_ptr[AW-1:0]]    <= req_reply_wanted;
                sent_q[wr_ptr[AW-1:0]]  <= 1'b0;
                wr_ptr                  <= wr_ptr + PTR_ONE;
            end

            if (rx_started) begin
                beat_cnt <= '0;
                if (reply_ok) reply_active   <= 1'b1;
                else          err_unexpected <= 1'b1;
            end else begin
                if (rx_data_valid && reply_active) beat_cnt <= beat_cnt + CW'(1);
                if (rx_done) reply_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_txn_tracker.sv
// Scoreboard bench for mem_txn_tracker: expected commands and reply tags are queued on accept
// and popped as the DUT issues commands and tags replies.
module tb_mem_txn_tracker;

    localparam int DEPTH    = 4;
    localparam int CMD_BITS = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [CMD_BITS-1:0] req_cmd;
    logic                req_reply_wanted;
    logic                flush;
    logic                tx_command_valid;
    logic [CMD_BITS-1:0] tx_command;
    logic                tx_command_started;
    logic                tx_done;
    logic                rx_started;
    logic                rx_data_valid;
    logic                rx_done;
    logic                reply_active;
    logic [1:0]          reply_tag;
    logic                reply_hi_half;
    logic [2:0]          outstanding;
    logic                idle;
    logic                err_unexpected;

    mem_txn_tracker #(
        .NSHIFT(2), .PAYLOAD_CYCLES(8), .DEPTH(DEPTH), .CMD_BITS(CMD_BITS)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_reply_wanted(req_reply_wanted), .flush(flush),
        .tx_command_valid(tx_command_valid), .tx_command(tx_command),
        .tx_command_started(tx_command_started), .tx_done(tx_done),
        .rx_started(rx_started), .rx_data_valid(rx_data_valid), .rx_done(rx_done),
        .reply_active(reply_active), .reply_tag(reply_tag), .reply_hi_half(reply_hi_half),
        .outstanding(outstanding), .idle(idle), .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_wr   = 0;
    logic [CMD_BITS-1:0] exp_cmd_q [$];
    logic [1:0]          exp_tag_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = 0; req_cmd = '0; req_reply_wanted = 0; flush = 0;
        tx_command_started = 0; tx_done = 0;
        rx_started = 0; rx_data_valid = 0; rx_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        exp_cmd_q.delete();
        exp_tag_q.delete();
        tb_wr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
        tick();
    endtask

    task automatic push_req(input logic [CMD_BITS-1:0] cmd, input logic rw);
        req_valid = 1; req_cmd = cmd; req_reply_wanted = rw;
        exp_cmd_q.push_back(cmd);
        if (rw) exp_tag_q.push_back(2'(tb_wr % DEPTH));
        tb_wr++;
        tick();
        req_valid = 0;
    endtask

    task automatic issue_one(output bit ok, output logic [CMD_BITS-1:0] cmd_seen);
        ok = 0;
        cmd_seen = 'x;
        for (int i = 0; i < 20; i++) begin
            if (tx_command_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) return;
        cmd_seen = tx_command;
        tx_command_started = 1;
        tick();
        tx_command_started = 0;
        tick();
        tx_done = 1;
        tick();
        tx_done = 0;
    endtask

    task automatic reply_one(output logic active, output logic [1:0] tag, output logic [7:0] hi);
        rx_started = 1;
        tick();
        rx_started = 0;
        active = reply_active;
        tag = reply_tag;
        hi = '0;
        for (int k = 0; k < 8; k++) begin
            rx_data_valid = 1;
            rx_done = (k == 7);
            hi[k] = reply_hi_half;
            tick();
        end
        rx_data_valid = 0;
        rx_done = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        #1;
        n_tests++;
        if ({tx_command_valid, reply_active, reply_hi_half, err_unexpected} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got valid/active/hi/err=%b want 0000",
                     {tx_command_valid, reply_active, reply_hi_half, err_unexpected});
        end
        n_tests++;
        if (outstanding !== 3'd0 || idle !== 1'b1 || reply_tag !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_status: got outstanding=%0d idle=%b tag=%0d want 0 1 0",
                     outstanding, idle, reply_tag);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
        tick();
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [CMD_BITS-1:0] c;
        logic act;
        logic [1:0] tag;
        logic [7:0] hi;
        logic [1:0] et;
        do_reset();
        req_valid = 1; req_cmd = 3'd1; req_reply_wanted = 1;
        #1;
        n_tests++;
        if (tx_command_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_valid_early: got %b want 0", tx_command_valid);
        end
        push_req(3'd1, 1'b1);
        n_tests++;
        if (tx_command_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_valid_rise: got %b want 1", tx_command_valid);
        end
        push_req(3'd1, 1'b1);
        push_req(3'd1, 1'b1);
        n_tests++;
        if (outstanding !== 3'd3) begin
            n_fail++;
            $display("FAIL b2b_outstanding3: got %0d want 3", outstanding);
        end
        for (int i = 0; i < 3; i++) begin
            issue_one(ok, c);
            n_tests++;
            if (!ok || c !== exp_cmd_q[0]) begin
                n_fail++;
                $display("FAIL b2b_issue%0d: got ok=%b cmd=%0d want cmd=%0d", i, ok, c, exp_cmd_q[0]);
            end
            void'(exp_cmd_q.pop_front());
            n_tests++;
            if (tx_command_valid !== (i < 2)) begin
                n_fail++;
                $display("FAIL b2b_next_offer%0d: got %b want %b", i, tx_command_valid, (i < 2));
            end
            reply_one(act, tag, hi);
            et = exp_tag_q.pop_front();
            n_tests++;
            if (act !== 1'b1 || tag !== et || hi !== 8'hF0) begin
                n_fail++;
                $display("FAIL b2b_reply%0d: got active=%b tag=%0d hi=%b want 1 %0d 11110000",
                         i, act, tag, hi, et);
            end
            n_tests++;
            if (outstanding !== 3'(2 - i) || reply_active !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_retire%0d: got outstanding=%0d active=%b want %0d 0",
                         i, outstanding, reply_active, 2 - i);
            end
        end
        n_tests++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle: got %b want 1", idle);
        end
    endtask

    task automatic test_full();
        bit ok;
        logic [CMD_BITS-1:0] c;
        logic act;
        logic [1:0] tag;
        logic [7:0] hi;
        logic [1:0] et;
        do_reset();
        push_req(3'd2, 1'b1);
        push_req(3'd3, 1'b1);
        push_req(3'd4, 1'b1);
        push_req(3'd5, 1'b1);
        n_tests++;
        if (req_ready !== 1'b0 || outstanding !== 3'd4) begin
            n_fail++;
            $display("FAIL full_state: got ready=%b outstanding=%0d want 0 4", req_ready, outstanding);
        end
        req_valid = 1; req_cmd = 3'd7; req_reply_wanted = 1;
        tick();
        req_valid = 0;
        n_tests++;
        if (outstanding !== 3'd4) begin
            n_fail++;
            $display("FAIL full_no_accept: got outstanding=%0d want 4", outstanding);
        end
        issue_one(ok, c);
        n_tests++;
        if (!ok || c !== exp_cmd_q[0]) begin
            n_fail++;
            $display("FAIL full_issue0: got ok=%b cmd=%0d want %0d", ok, c, exp_cmd_q[0]);
        end
        void'(exp_cmd_q.pop_front());
        reply_one(act, tag, hi);
        et = exp_tag_q.pop_front();
        n_tests++;
        if (act !== 1'b1 || tag !== et) begin
            n_fail++;
            $display("FAIL full_reply0: got active=%b tag=%0d want 1 %0d", act, tag, et);
        end
        n_tests++;
        if (req_ready !== 1'b1 || outstanding !== 3'd3) begin
            n_fail++;
            $display("FAIL full_after_retire: got ready=%b outstanding=%0d want 1 3", req_ready, outstanding);
        end
        push_req(3'd6, 1'b1);
        n_tests++;
        if (outstanding !== 3'd4) begin
            n_fail++;
            $display("FAIL full_wrap_accept: got outstanding=%0d want 4", outstanding);
        end
        for (int i = 0; i < 4; i++) begin
            issue_one(ok, c);
            n_tests++;
            if (!ok || c !== exp_cmd_q[0]) begin
                n_fail++;
                $display("FAIL full_issue%0d: got ok=%b cmd=%0d want %0d", i + 1, ok, c, exp_cmd_q[0]);
            end
            void'(exp_cmd_q.pop_front());
            reply_one(act, tag, hi);
            et = exp_tag_q.pop_front();
            n_tests++;
            if (act !== 1'b1 || tag !== et) begin
                n_fail++;
                $display("FAIL full_reply%0d: got active=%b tag=%0d want 1 %0d", i + 1, act, tag, et);
            end
        end
        n_tests++;
        if (outstanding !== 3'd0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drain: got outstanding=%0d idle=%b want 0 1", outstanding, idle);
        end
    endtask

    task automatic test_mixed();
        bit ok;
        logic [CMD_BITS-1:0] c;
        logic act;
        logic [1:0] tag;
        logic [7:0] hi;
        logic [1:0] et;
        do_reset();
        push_req(3'd5, 1'b0);
        push_req(3'd1, 1'b1);
        issue_one(ok, c);
        n_tests++;
        if (!ok || c !== exp_cmd_q[0]) begin
            n_fail++;
            $display("FAIL mixed_issue_wr: got ok=%b cmd=%0d want %0d", ok, c, exp_cmd_q[0]);
        end
        void'(exp_cmd_q.pop_front());
        n_tests++;
        if (outstanding !== 3'd2) begin
            n_fail++;
            $display("FAIL mixed_wr_not_yet: got outstanding=%0d want 2", outstanding);
        end
        tick();
        n_tests++;
        if (outstanding !== 3'd1) begin
            n_fail++;
            $display("FAIL mixed_wr_retired: got outstanding=%0d want 1", outstanding);
        end
        issue_one(ok, c);
        n_tests++;
        if (!ok || c !== exp_cmd_q[0]) begin
            n_fail++;
            $display("FAIL mixed_issue_rd: got ok=%b cmd=%0d want %0d", ok, c, exp_cmd_q[0]);
        end
        void'(exp_cmd_q.pop_front());
        reply_one(act, tag, hi);
        et = exp_tag_q.pop_front();
        n_tests++;
        if (act !== 1'b1 || tag !== et || hi !== 8'hF0) begin
            n_fail++;
            $display("FAIL mixed_reply: got active=%b tag=%0d hi=%b want 1 %0d 11110000", act, tag, hi, et);
        end
        n_tests++;
        if (err_unexpected !== 1'b0 || outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL mixed_end: got err=%b outstanding=%0d want 0 0", err_unexpected, outstanding);
        end
    endtask

    task automatic test_unexpected();
        do_reset();
        rx_started = 1;
        tick();
        rx_started = 0;
        n_tests++;
        if (err_unexpected !== 1'b1 || reply_active !== 1'b0) begin
            n_fail++;
            $display("FAIL unexp_set: got err=%b active=%b want 1 0", err_unexpected, reply_active);
        end
        repeat (5) tick();
        n_tests++;
        if (err_unexpected !== 1'b1 || reply_active !== 1'b0) begin
            n_fail++;
            $display("FAIL unexp_sticky: got err=%b active=%b want 1 0", err_unexpected, reply_active);
        end
    endtask

    task automatic test_flush();
        bit ok;
        logic [CMD_BITS-1:0] c;
        logic act;
        logic [1:0] tag;
        logic [7:0] hi;
        logic [1:0] et;
        do_reset();
        push_req(3'd1, 1'b1);
        push_req(3'd2, 1'b1);
        push_req(3'd3, 1'b1);
        c = tx_command;
        tx_command_started = 1;
        flush = 1;
        req_valid = 1; req_cmd = 3'd4; req_reply_wanted = 1;
        #1;
        n_tests++;
        if (req_ready !== 1'b0 || c !== exp_cmd_q[0]) begin
            n_fail++;
            $display("FAIL flush_cycle: got ready=%b cmd=%0d want 0 %0d", req_ready, c, exp_cmd_q[0]);
        end
        tick();
        tx_command_started = 0; flush = 0; req_valid = 0;
        void'(exp_cmd_q.pop_front());
        void'(exp_cmd_q.pop_back());
        void'(exp_cmd_q.pop_back());
        void'(exp_tag_q.pop_back());
        void'(exp_tag_q.pop_back());
        tb_wr = 1;
        n_tests++;
        if (outstanding !== 3'd1) begin
            n_fail++;
            $display("FAIL flush_outstanding: got %0d want 1", outstanding);
        end
        tick();
        tx_done = 1;
        tick();
        tx_done = 0;
        n_tests++;
        if (tx_command_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_offer: got %b want 0", tx_command_valid);
        end
        repeat (3) tick();
        n_tests++;
        if (tx_command_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_offer_later: got %b want 0", tx_command_valid);
        end
        reply_one(act, tag, hi);
        et = exp_tag_q.pop_front();
        n_tests++;
        if (act !== 1'b1 || tag !== et || outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_reply0: got active=%b tag=%0d outstanding=%0d want 1 %0d 0",
                     act, tag, outstanding, et);
        end
        push_req(3'd7, 1'b1);
        issue_one(ok, c);
        n_tests++;
        if (!ok || c !== exp_cmd_q[0]) begin
            n_fail++;
            $display("FAIL flush_new_issue: got ok=%b cmd=%0d want %0d", ok, c, exp_cmd_q[0]);
        end
        void'(exp_cmd_q.pop_front());
        reply_one(act, tag, hi);
        et = exp_tag_q.pop_front();
        n_tests++;
        if (act !== 1'b1 || tag !== et || outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_new_reply: got active=%b tag=%0d outstanding=%0d want 1 %0d 0",
                     act, tag, outstanding, et);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [CMD_BITS-1:0] c;
        do_reset();
        push_req(3'd1, 1'b1);
        issue_one(ok, c);
        rx_started = 1;
        tick();
        rx_started = 0;
        rx_data_valid = 1;
        repeat (5) tick();
        rx_data_valid = 0;
        n_tests++;
        if (!ok || reply_active !== 1'b1 || reply_hi_half !== 1'b1 || outstanding !== 3'd1) begin
            n_fail++;
            $display("FAIL areset_pre: got ok=%b active=%b hi=%b outstanding=%0d want 1 1 1 1",
                     ok, reply_active, reply_hi_half, outstanding);
        end
        #2;
        reset = 0;
        #1;
        n_tests++;
        if ({reply_active, reply_hi_half, tx_command_valid, err_unexpected} !== 4'b0000 ||
            outstanding !== 3'd0 || idle !== 1'b1 || reply_tag !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got active/hi/valid/err=%b outstanding=%0d idle=%b tag=%0d want 0000 0 1 0",
                     {reply_active, reply_hi_half, tx_command_valid, err_unexpected},
                     outstanding, idle, reply_tag);
        end
        exp_cmd_q.delete();
        exp_tag_q.delete();
        @(negedge clk);
        reset = 1;
        tick();
        n_tests++;
        if (idle !== 1'b1 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_release: got idle=%b ready=%b want 1 1", idle, req_ready);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 0;
        test_reset();
        test_back_to_back();
        test_full();
        test_mixed();
        test_unexpected();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_txn_tracker.md
Name: mem_txn_tracker

Overview:
- Parametrised successor to the single-command TX/RX handling inside the instruction scheduler.
- Queues up to DEPTH memory commands from the scheduler and issues them to the TX interface one at a time, in order.
- Tracks each command in flight and matches RX replies in order to the oldest command that wants one. Commands with no reply wanted retire on tx_done, which removes the single-outstanding and fixed-reply_wanted limits.
- Sits between the scheduler and the TX/RX serial engines.

Parameters:
- NSHIFT, 2, bits per serial beat.
- PAYLOAD_CYCLES, 8, RX data beats per 16-bit reply.
- DEPTH, 4, queue entries; must be a power of two, >=2.
- CMD_BITS, 3, width of a TX command header code.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  scheduler offers a command.
- req_ready  out  1  entry free and no flush.
- req_cmd  in  CMD_BITS  TX header code.
- req_reply_wanted  in  1  an RX reply will follow.
- flush  in  1  drop all not-yet-issued entries.
- tx_command_valid  out  1  head-of-issue command offered to TX.
- tx_command  out  CMD_BITS  header of that command.
- tx_command_started  in  1  TX accepted the offered command.
- tx_done  in  1  TX finished the in-flight command.
- rx_started  in  1  RX reply header detected.
- rx_data_valid  in  1  RX data beat present.
- rx_done  in  1  last RX beat.
- reply_active  out  1  current RX beat belongs to a tracked reply.
- reply_tag  out  log2(DEPTH)  entry index owning the current reply.
- reply_hi_half  out  1  beat lies in the second half of the payload.
- outstanding  out  log2(DEPTH)+1  entries not yet retired.
- idle  out  1  outstanding==0 and no TX in flight.
- err_unexpected  out  1  sticky: RX reply arrived with no wanted entry.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {cmd, reply_wanted, sent}.
- Pointers:
  - wr_ptr: next entry to fill.
  - iss_ptr: next entry to issue.
  - ret_ptr: oldest unretired entry.
  - Each pointer is one bit wider than log2(DEPTH); wrap is modulo 2*DEPTH.
  - full = (wr_ptr - ret_ptr) == DEPTH.
- Reset (reset=0, asynchronous):
  - All pointers 0, sent bits 0, beat counter 0.
  - inflight=0, err_unexpected=0.
  - Outputs: tx_command_valid=0, reply_active=0, reply_tag=0, reply_hi_half=0, outstanding=0, idle=1, req_ready=1 once reset is released.
- Accept:
  - req_ready = !full && !flush.
  - On req_valid && req_ready, write the entry at wr_ptr with sent=0, then wr_ptr++.
  - Accept and retire in the same cycle are both allowed; outstanding is unchanged.
- Issue FSM, states ISSUE_IDLE and INFLIGHT:
  - In ISSUE_IDLE: tx_command_valid = (iss_ptr != wr_ptr), and tx_command = cmd[iss_ptr].
  - Combinational issue path: a request accepted in cycle N is visible on tx_command_valid in cycle N+1.
  - On tx_command_started, move to INFLIGHT and iss_ptr++.
  - In INFLIGHT: tx_command_valid=0. On tx_done, set sent on the in-flight entry and return to ISSUE_IDLE.
  - At most one command is in TX at a time.
- Retire:
  - The head at ret_ptr retires when either:
    - !reply_wanted && sent (retires in the cycle after sent is set); or
    - reply_wanted && rx_done && reply_active.
  - Retirement clears sent. At most one retirement per cycle, strictly in order.
- Reply matching:
  - rx_started sets reply_active when the head wants a reply and is sent, or is in flight.
  - RX may start before tx_done is seen, so the in-flight case counts.
  - reply_tag = ret_ptr[log2(DEPTH)-1:0].
  - Beat counter:
    - Cleared on rx_started.
    - Increments on rx_data_valid while reply_active.
    - Width log2(PAYLOAD_CYCLES)+1.
  - reply_hi_half = counter[log2(PAYLOAD_CYCLES)-1] (the counter's MSB minus one).
  - reply_active clears the cycle after rx_done.
  - rx_started with no qualifying head (empty, or head not wanting a reply) sets err_unexpected and leaves reply_active=0.
- Flush:
  - Sets wr_ptr := iss_ptr; this also covers a command offered but not yet started.
  - Does not touch the in-flight command or sent/outstanding entries.
  - If tx_command_started coincides with flush, the started command is kept (iss_ptr++ first, wr_ptr := new iss_ptr).
  - No accept occurs during flush.
- Status:
  - outstanding = wr_ptr - ret_ptr.
  - idle = (outstanding==0) && state==ISSUE_IDLE.

Test Plan:
- Back-to-back issue: 3 reads accepted, reply_wanted=1 (cmd=3'd1 each).
  - tx_command_valid rises the cycle after the first accept.
  - After each tx_done, the next cmd is offered.
  - Three replies of 8 beats give reply_tag 0,1,2.
  - reply_hi_half is high on beats 4..7.
  - outstanding goes 3→0, then idle=1.
- Full: accept 4 with DEPTH=4.
  - req_ready=0 and outstanding=4.
  - Retire one: req_ready=1 the same cycle.
  - A 5th accept writes entry 0 (wrap); reply_tag then reads 0.
- Mixed write with no reply: write (reply_wanted=0) then read.
  - Write retires 1 cycle after its tx_done.
  - The RX reply is tagged 1.
  - err_unexpected stays 0.
- Unexpected RX: rx_started while empty.
  - err_unexpected=1 and stays 1.
  - reply_active stays 0.
- Flush: 3 queued, first started.
  - flush in the same cycle as tx_command_started gives outstanding=1.
  - tx_command_valid=0 after tx_done until a new accept.
- Async reset: pull reset low mid-reply.
  - All outputs return to reset values immediately, without waiting for a clk edge.
  - idle=1 after release.
